gshare_update: RTL and testbench

Branch resolution and predictor-update unit. It is the write side of the gshare/BTB prediction interface: it owns the PHT and the GHSR, and serves the IF-stage lookup. It sits between EX, where branches and jumps resolve, and IF/PC, where redirects land. Each resolved branch is compared against the `branch_predict_type` it carried down the pipe; the block raises a registered mispredict/redirect, trains the 2-bit PHT counter, and repairs the speculative GHSR.

---
 rtl/gshare_update_pkg.sv | 29 ++
 rtl/gshare_pht.sv | 32 +++
 rtl/gshare_update.sv | 116 +++++++++++
 tb/tb_gshare_update.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gshare_update_pkg.sv
// rtl/gshare_update_pkg.sv - gshare constants, prediction bundle type, hash and counter helpers
package gshare_update_pkg;

  localparam int GSHARE_GHSR_WIDTH = 10;
  localparam int GSHARE_PHT_SIZE   = 1024;
  localparam int GSHARE_PHT_WIDTH  = $clog2(GSHARE_PHT_SIZE);
  localparam logic [1:0] PHT_INIT  = 2'b01;

  typedef struct packed {
    logic                         branch_taken_predict;
    logic                         branch_btb_hit;
    logic [31:0]                  branch_btb_addr;
    logic [GSHARE_GHSR_WIDTH-1:0] current_GHSR;
  } branch_predict_type;

  // PC bits [1:0] are always zero for aligned fetch, so they are skipped.
  function automatic logic [GSHARE_PHT_WIDTH-1:0] gshare_hash(
    input logic [GSHARE_GHSR_WIDTH-1:0] hist,
    input logic [31:0]                  pc
  );
    return pc[GSHARE_PHT_WIDTH+1:2] ^ hist;
  endfunction

  function automatic logic [1:0] pht_counter_update(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == 2'b11) ? ctr : ctr + 2'd1;
    return (ctr == 2'b00) ? ctr : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/gshare_pht.sv
// rtl/gshare_pht.sv - flop-based 2-bit counter table, two async read ports, one sync write port
module gshare_pht
  import gshare_update_pkg::*;
#(
  parameter int PHT_SIZE  = GSHARE_PHT_SIZE,
  parameter int PHT_WIDTH = GSHARE_PHT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [PHT_WIDTH-1:0] rd0_idx,
  output logic [1:0]           rd0_ctr,
  input  logic [PHT_WIDTH-1:0] rd1_idx,
  output logic [1:0]           rd1_ctr,
  input  logic                 wr_en,
  input  logic [PHT_WIDTH-1:0] wr_idx,
  input  logic [1:0]           wr_ctr
);

  logic [1:0] ctr_q [PHT_SIZE];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PHT_SIZE; i++) ctr_q[i] <= PHT_INIT;
    end else if (wr_en) begin
      ctr_q[wr_idx] <= wr_ctr;
    end
  end

  assign rd0_ctr = ctr_q[rd0_idx];
  assign rd1_ctr = ctr_q[rd1_idx];

endmodule

// File: rtl/gshare_update.sv
// rtl/gshare_update.sv - branch resolution, PHT training, GHSR repair and IF lookup
// Optional GSHARE_STATS_EN adds saturating resolve/mispredict counters.
module gshare_update
  import gshare_update_pkg::*;
#(
  parameter int GHSR_WIDTH = GSHARE_GHSR_WIDTH,
  parameter int PHT_SIZE   = GSHARE_PHT_SIZE,
  parameter int PHT_WIDTH  = GSHARE_PHT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [31:0]           lookup_pc,
  output logic                  lookup_taken,
  output logic [GHSR_WIDTH-1:0] ghsr,
  input  logic                  spec_valid,
  input  logic                  spec_taken,
  input  logic                  stall,
  input  logic                  res_valid,
  input  logic                  res_is_branch,
  input  logic [31:0]           res_pc,
  input  logic                  res_taken,
  input  logic [31:0]           res_target,
  input  branch_predict_type    res_predict,
  output logic                  mispredict,
  output logic [31:0]           redirect_pc,
  output logic [31:0]           stat_branches,
  output logic [31:0]           stat_mispredicts
);

  logic [PHT_WIDTH-1:0] lk_idx, rs_idx, u_idx;
  logic [1:0]           lk_pht, rs_pht, lk_ctr, rs_ctr, u_old, u_new;
  logic                 u_valid, u_taken;
  logic                 mis_now, train;
  logic [31:0]          redirect_now;
  logic                 unused_pc_bits;

  assign unused_pc_bits = ^{lookup_pc[31:PHT_WIDTH+2], lookup_pc[1:0]};

  assign lk_idx = gshare_hash(ghsr, lookup_pc);
  assign rs_idx = gshare_hash(res_predict.current_GHSR, res_pc);
  assign u_new  = pht_counter_update(u_old, u_taken);

  // Stage U's counter is not in the table yet; both readers must see it.
  assign lk_ctr = (u_valid && (u_idx == lk_idx)) ? u_new : lk_pht;
  assign rs_ctr = (u_valid && (u_idx == rs_idx)) ? u_new : rs_pht;

  assign lookup_taken = lk_ctr[1];
  assign train        = res_valid && res_is_branch;

  assign mis_now = res_valid &&
                   ((res_taken != res_predict.branch_taken_predict) ||
                    (res_taken && (!res_predict.branch_btb_hit ||
                                   (res_predict.branch_btb_addr != res_target))));
  assign redirect_now = res_taken ? res_target : res_pc + 32'd4;

  gshare_pht #(
    .PHT_SIZE  (PHT_SIZE),
    .PHT_WIDTH (PHT_WIDTH)
  ) u_pht (
    .clk     (clk),
    .reset_n (reset_n),
    .rd0_idx (lk_idx),
    .rd0_ctr (lk_pht),
    .rd1_idx (rs_idx),
    .rd1_ctr (rs_pht),
    .wr_en   (u_valid),
    .wr_idx  (u_idx),
    .wr_ctr  (u_new)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      u_valid     <= 1'b0;
      u_idx       <= '0;
      u_old       <= PHT_INIT;
      u_taken     <= 1'b0;
      mispredict  <= 1'b0;
      redirect_pc <= 32'd0;
      ghsr        <= '0;
    end else begin
      u_valid    <= train;
      if (train) begin
        u_idx   <= rs_idx;
        u_old   <= rs_ctr;
        u_taken <= res_taken;
      end
      mispredict <= mis_now;
      if (mis_now) redirect_pc <= redirect_now;
      // A same-cycle speculative shift belongs to the wrong path, so repair wins.
      if (mis_now) begin
        if (res_is_branch) ghsr <= {res_predict.current_GHSR[GHSR_WIDTH-2:0], res_taken};
        else               ghsr <= res_predict.current_GHSR;
      end else if (spec_valid && !stall) begin
        ghsr <= {ghsr[GHSR_WIDTH-2:0], spec_taken};
      end
    end
  end

`ifdef GSHARE_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_branches    <= 32'd0;
      stat_mispredicts <= 32'd0;
    end else begin
      if (res_valid && (stat_branches != 32'hFFFF_FFFF))
        stat_branches <= stat_branches + 32'd1;
      if (mis_now && (stat_mispredicts != 32'hFFFF_FFFF))
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`else
  assign stat_branches    = 32'd0;
  assign stat_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_gshare_update.sv
// tb/tb_gshare_update.sv - directed and randomized checks of gshare_update against a table model
module tb_gshare_update;
  import gshare_update_pkg::*;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [31:0]        lookup_pc;
  logic               lookup_taken;
  logic [9:0]         ghsr;
  logic               spec_valid, spec_taken, stall;
  logic               res_valid, res_is_branch, res_taken;
  logic [31:0]        res_pc, res_target;
  branch_predict_type res_predict;
  logic               mispredict;
  logic [31:0]        redirect_pc, stat_branches, stat_mispredicts;

  int n_chk = 0;
  int n_err = 0;

  int          m_pht [1024];
  int          m_ghsr;
  logic        exp_mis;
  logic [31:0] exp_red;
  int          exp_br, exp_mp;
  int          last_idx;

  always #5 clk = ~clk;

  gshare_update dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .lookup_pc        (lookup_pc),
    .lookup_taken     (lookup_taken),
    .ghsr             (ghsr),
    .spec_valid       (spec_valid),
    .spec_taken       (spec_taken),
    .stall            (stall),
    .res_valid        (res_valid),
    .res_is_branch    (res_is_branch),
    .res_pc           (res_pc),
    .res_taken        (res_taken),
    .res_target       (res_target),
    .res_predict      (res_predict),
    .mispredict       (mispredict),
    .redirect_pc      (redirect_pc),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc, input int hist);
    return int'((pc >> 2) % 1024) ^ hist;
  endfunction

  function automatic logic [31:0] lpc_for(input int idx);
    return 32'((idx ^ m_ghsr) * 4);
  endfunction

  function automatic branch_predict_type mkp(input logic tk, input logic hit,
                                             input logic [31:0] addr, input int cg);
    branch_predict_type p;
    p.branch_taken_predict = tk;
    p.branch_btb_hit       = hit;
    p.branch_btb_addr      = addr;
    p.current_GHSR         = 10'(cg);
    return p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 1024; i++) m_pht[i] = 1;
    m_ghsr  = 0;
    exp_mis = 1'b0;
    exp_red = 32'd0;
    exp_br  = 0;
    exp_mp  = 0;
  endtask

  task automatic model_step();
    logic m;
    int   cg, i;
    m  = 1'b0;
    cg = int'(res_predict.current_GHSR);
    if (res_valid) begin
      m = (res_taken != res_predict.branch_taken_predict) ||
          (res_taken && (!res_predict.branch_btb_hit || res_predict.branch_btb_addr != res_target));
      exp_br++;
      if (m) exp_mp++;
      if (res_is_branch) begin
        i = idx_of(res_pc, cg);
        if (res_taken) m_pht[i] = (m_pht[i] < 3) ? m_pht[i] + 1 : 3;
        else           m_pht[i] = (m_pht[i] > 0) ? m_pht[i] - 1 : 0;
      end
    end
    exp_mis = m;
    if (m) begin
      exp_red = res_taken ? res_target : res_pc + 32'd4;
      m_ghsr  = res_is_branch ? ((cg * 2) + int'(res_taken)) % 1024 : cg;
    end else if (spec_valid && !stall) begin
      m_ghsr = ((m_ghsr * 2) + int'(spec_taken)) % 1024;
    end
  endtask

  task automatic cycle();
    #1;
    chk("lookup_taken", lookup_taken, (m_pht[idx_of(lookup_pc, m_ghsr)] >= 2));
    model_step();
    @(negedge clk);
    chk("mispredict", mispredict, exp_mis);
    if (exp_mis) chk("redirect_pc", redirect_pc, exp_red);
    chk("ghsr", ghsr, m_ghsr);
`ifdef GSHARE_STATS_EN
    chk("stat_branches", stat_branches, exp_br);
    chk("stat_mispredicts", stat_mispredicts, exp_mp);
`else
    chk("stat_branches", stat_branches, 0);
    chk("stat_mispredicts", stat_mispredicts, 0);
`endif
    res_valid  = 1'b0;
    spec_valid = 1'b0;
    stall      = 1'b0;
  endtask

  task automatic resolve(input logic br, input logic [31:0] pc, input logic tk,
                         input logic [31:0] tgt, input branch_predict_type p);
    res_valid     = 1'b1;
    res_is_branch = br;
    res_pc        = pc;
    res_taken     = tk;
    res_target    = tgt;
    res_predict   = p;
  endtask

  initial begin
    reset_n       = 1'b0;
    lookup_pc     = 32'h100;
    spec_valid    = 1'b0;
    spec_taken    = 1'b0;
    stall         = 1'b0;
    res_valid     = 1'b0;
    res_is_branch = 1'b0;
    res_pc        = 32'd0;
    res_taken     = 1'b0;
    res_target    = 32'd0;
    res_predict   = mkp(1'b0, 1'b0, 32'd0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    chk("rst_mispredict", mispredict, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_ghsr", ghsr, 0);
    lookup_pc = 32'h100;
    cycle();

    // Taken branch predicted not-taken at 0x40, history 0x003.
    resolve(1'b1, 32'h40, 1'b1, 32'h80, mkp(1'b0, 1'b0, 32'd0, 3));
    cycle();
    chk("dir_redirect_0x80", redirect_pc, 32'h80);
    chk("dir_ghsr_0x007", ghsr, 32'h7);
    lookup_pc = lpc_for(32'h3 ^ 32'h10);
    cycle();
    chk("dir_lookup_trained", lookup_taken, 1);

    // Back-to-back training of one entry, then two decrements.
    for (int k = 0; k < 5; k++) begin
      if (k < 3) resolve(1'b1, 32'h80, 1'b1, 32'h300, mkp(1'b1, 1'b1, 32'h300, 0));
      else       resolve(1'b1, 32'h80, 1'b0, 32'h300, mkp(1'b0, 1'b0, 32'd0, 0));
      lookup_pc = lpc_for(32'h20);
      cycle();
    end
    lookup_pc = lpc_for(32'h20);
    cycle();

    resolve(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, mkp(1'b0, 1'b0, 32'd0, 5));
    cycle();
    resolve(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, mkp(1'b1, 1'b1, 32'h1234, 5));
    cycle();
    chk("wrap_redirect", redirect_pc, 32'h0);

    // BTB target mismatch with a simultaneous speculative shift.
    resolve(1'b1, 32'h60, 1'b1, 32'h204, mkp(1'b1, 1'b1, 32'h200, 9));
    spec_valid = 1'b1;
    spec_taken = 1'b0;
    cycle();
    lookup_pc = lpc_for(idx_of(32'h60, 9));
    cycle();

    // Reset during the cycle a stage-U write is pending.
    resolve(1'b1, 32'h44, 1'b1, 32'h90, mkp(1'b0, 1'b0, 32'd0, 0));
    lookup_pc = 32'h44;
    cycle();
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    chk("rst_mid_mispredict", mispredict, 0);
    lookup_pc = 32'h44;
    cycle();

    // Five resolves, two of them mispredicts.
    resolve(1'b1, 32'h10, 1'b1, 32'h50, mkp(1'b1, 1'b1, 32'h50, 1)); cycle();
    resolve(1'b1, 32'h14, 1'b0, 32'h50, mkp(1'b1, 1'b0, 32'h0, 1));  cycle();
    resolve(1'b0, 32'h18, 1'b1, 32'h70, mkp(1'b1, 1'b1, 32'h70, 2)); cycle();
    resolve(1'b0, 32'h1C, 1'b1, 32'h74, mkp(1'b1, 1'b1, 32'h78, 2)); cycle();
    resolve(1'b1, 32'h20, 1'b0, 32'h0,  mkp(1'b0, 1'b0, 32'h0, 3));  cycle();

    last_idx = 0;
    for (int n = 0; n < 400; n++) begin
      logic br;
      logic [31:0] pc, tgt;
      int cg;
      br  = ($urandom_range(0, 3) != 0);
      pc  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : 32'($urandom_range(0, 15) * 4);
      tgt = $urandom & 32'hFFFF_FFFC;
      cg  = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        resolve(br, pc, br ? 1'($urandom) : 1'b1, tgt,
                mkp(1'($urandom), 1'($urandom),
                    ($urandom_range(0, 1) == 1) ? tgt : ($urandom & 32'hFFFF_FFFC), cg));
        if (br) last_idx = idx_of(pc, cg);
      end
      spec_valid = 1'($urandom);
      spec_taken = 1'($urandom);
      stall      = ($urandom_range(0, 3) == 0);
      lookup_pc  = ($urandom_range(0, 1) == 1) ? lpc_for(last_idx) : ($urandom & 32'hFFFF_FFFC);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
